// File: rtl/theremin_audio_pkg.sv
// Shared definitions for the theremin audio path.
//   SAMPLE_W         : PCM width per channel (two's complement, MSB-first)
//   SLOT_BITS        : BCLK periods per channel half of an I2S frame
//   FRAME_BITS       : BCLK periods per stereo frame
//   BCLK_DIV_DEFAULT : clk cycles per BCLK half-period at 50 MHz
//   stereo_sample_t  : one stereo PCM sample {left, right}
package theremin_audio_pkg;

   localparam int SAMPLE_W         = 16;
   localparam int SLOT_BITS        = 32;
   localparam int FRAME_BITS       = 64;
   localparam int BCLK_DIV_DEFAULT = 8;

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator for the I2S transmitter.
// Ports:
//   clk   (in)  : system clock
//   reset (in)  : synchronous active-high reset
//   bclk  (out) : bit clock, toggles every BCLK_DIV clk cycles
//   fall  (out) : strobe, high in the cycle whose edge takes bclk 1->0
module i2s_clk_gen #(
   parameter int BCLK_DIV = 8
) (
   input  logic clk,
   input  logic reset,
   output logic bclk,
   output logic fall
);

   localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BCLK_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic          wrap;

   assign wrap = (div_cnt == LAST);
   // Combinational so the consumer updates on the same edge that drops bclk.
   assign fall = wrap & bclk;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the WM8731 DAC (codec in slave mode).
// Accepts stereo PCM samples on a valid/ready sink and serialises them
// MSB-first with the standard one-BCLK delay after each LRCK edge.
// Ports:
//   clk_clk      (in)  : system clock
//   reset_reset  (in)  : synchronous active-high reset
//   snk_valid    (in)  : stereo sample present
//   snk_ready    (out) : holding register empty
//   snk_left     (in)  : left sample
//   snk_right    (in)  : right sample
//   aud_bclk     (out) : bit clock to codec
//   aud_daclrck  (out) : 0 = left channel, 1 = right channel
//   aud_dacdat   (out) : serial data, changes on BCLK falling edges
//   underrun     (out) : one-cycle pulse when a frame starts with no new sample
//   underrun_cnt (out) : saturating underrun count
// Handshake: a transfer happens on a clk edge where snk_valid and snk_ready
// are both high; snk_valid may rise at any time, and the data must be held
// stable while snk_valid is high and snk_ready is low.
module i2s_dac_tx #(
   parameter int SAMPLE_W = theremin_audio_pkg::SAMPLE_W,
   parameter int BCLK_DIV = theremin_audio_pkg::BCLK_DIV_DEFAULT
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic                snk_valid,
   output logic                snk_ready,
   input  logic [SAMPLE_W-1:0] snk_left,
   input  logic [SAMPLE_W-1:0] snk_right,
   output logic                aud_bclk,
   output logic                aud_daclrck,
   output logic                aud_dacdat,
   output logic                underrun,
   output logic [15:0]         underrun_cnt
);

   import theremin_audio_pkg::*;

   localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

   logic                bclk;
   logic                fall;
   logic [5:0]          bit_cnt;
   logic [5:0]          bit_cnt_nxt;
   logic                hold_full;
   logic [SAMPLE_W-1:0] hold_left;
   logic [SAMPLE_W-1:0] hold_right;
   logic [SAMPLE_W-1:0] shadow_left;
   logic [SAMPLE_W-1:0] shadow_right;
   logic                accept;
   logic                frame_start;
   logic [4:0]          slot;
   logic [SAMPLE_W-1:0] chan;
   logic [SAMPLE_W-1:0] shifted;
   logic                next_bit;

   i2s_clk_gen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_clk_gen (
      .clk   (clk_clk),
      .reset (reset_reset),
      .bclk  (bclk),
      .fall  (fall)
   );

   assign aud_bclk    = bclk;
   assign aud_daclrck = bit_cnt[5];
   assign snk_ready   = ~hold_full & ~reset_reset;
   assign accept      = snk_valid & snk_ready;
   assign frame_start = fall & (bit_cnt == LAST_BIT);
   assign bit_cnt_nxt = bit_cnt + 6'd1;

   // Bit for the slot being entered on this fall strobe. Slot 0 is the
   // I2S delay bit; slots 1..SAMPLE_W carry MSB..LSB; the rest pad with 0.
   // At frame start the slot is 0, so the shadow reload on that same edge
   // never races with the data path.
   always_comb begin
      slot     = bit_cnt_nxt[4:0];
      chan     = bit_cnt_nxt[5] ? shadow_right : shadow_left;
      shifted  = chan << (slot - 5'd1);
      next_bit = 1'b0;
      if (slot != 5'd0 && int'(slot) <= SAMPLE_W) begin
         next_bit = shifted[SAMPLE_W-1];
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         bit_cnt      <= '0;
         aud_dacdat   <= 1'b0;
         hold_full    <= 1'b0;
         hold_left    <= '0;
         hold_right   <= '0;
         shadow_left  <= '0;
         shadow_right <= '0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         underrun <= 1'b0;

         if (fall) begin
            bit_cnt    <= bit_cnt_nxt;
            aud_dacdat <= next_bit;
         end

         // Frame start uses the hold state from before this edge, so a
         // sample accepted in the same cycle waits for the next frame.
         if (frame_start) begin
            if (hold_full) begin
               shadow_left  <= hold_left;
               shadow_right <= hold_right;
            end else begin
               underrun <= 1'b1;
               if (underrun_cnt != 16'hFFFF) begin
                  underrun_cnt <= underrun_cnt + 16'd1;
               end
            end
         end

         // accept requires hold empty, so it never collides with a load.
         if (accept) begin
            hold_left  <= snk_left;
            hold_right <= snk_right;
            hold_full  <= 1'b1;
         end else if (frame_start && hold_full) begin
            hold_full <= 1'b0;
         end
      end
   end

endmodule
